// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control sequencer sharing one memory port for fetch and data.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes/functs (adds TRAP state and `illegal` port).
module mc_ctrl_fsm #(
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       mem_timeout,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
        S_IEXEC = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
        S_JAL = 4'd12, S_JR = 4'd13, S_TRAP = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
                           OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110,
                           OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
    localparam logic [5:0] F_JR = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_NOR = 4'd10, ALU_SLLV = 4'd11,
                           ALU_SRLV = 4'd12, ALU_SRAV = 4'd13, ALU_LUI = 4'd14;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        r_alu, i_alu;
    logic              r_known, waiting, limit_hit;
    state_t            bad_next;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bad_next = S_TRAP;
    assign illegal  = (state_q == S_TRAP);
`else
    assign bad_next = S_FETCH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        r_known = 1'b1;
        case (funct)
            6'b100000, 6'b100001: r_alu = ALU_ADD;
            6'b100010, 6'b100011: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            6'b101011: r_alu = ALU_SLTU;
            6'b000000: r_alu = ALU_SLL;
            6'b000010: r_alu = ALU_SRL;
            6'b000011: r_alu = ALU_SRA;
            6'b000100: r_alu = ALU_SLLV;
            6'b000110: r_alu = ALU_SRLV;
            6'b000111: r_alu = ALU_SRAV;
            default: begin
                r_alu   = ALU_ADD;
                r_known = 1'b0;
            end
        endcase
        case (opcode)
            OP_ANDI:  i_alu = ALU_AND;
            OP_ORI:   i_alu = ALU_OR;
            OP_XORI:  i_alu = ALU_XOR;
            OP_SLTI:  i_alu = ALU_SLT;
            OP_SLTIU: i_alu = ALU_SLTU;
            OP_LUI:   i_alu = ALU_LUI;
            default:  i_alu = ALU_ADD;
        endcase
    end

    // A timeout retries the access in place: state holds, only the counter restarts.
    assign waiting   = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready;
    assign limit_hit = (MAX_WAIT != 0) && waiting && (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign wait_d    = (waiting && !limit_hit) ? wait_q + WAIT_W'(1) : '0;
    assign mem_timeout = limit_hit && rst_n;
    assign state       = state_q;

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = (funct == F_JR) ? S_JR : S_REXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_SLTIU, OP_LUI: state_d = S_IEXEC;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = bad_next;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_REXEC: begin
                alu_src_a   = 1'b1;
                alu_control = r_alu;
                state_d     = r_known ? S_RWB : bad_next;
            end
            S_RWB: begin
                reg_write   = 1'b1;
                reg_dst     = 2'b01;
                alu_control = r_alu;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = i_alu;
                state_d     = S_IWB;
            end
            S_IWB: begin
                reg_write   = 1'b1;
                alu_control = i_alu;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_write    = zero ^ (opcode == OP_BNE);
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed cases then random instructions with random memory stalls,
// checked against an instruction-level plan of expected states and controls.
module tb_mc_ctrl_fsm;

    localparam int MW = 3;
    localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05,
                           LW = 6'h23, SW = 6'h2b, F_JR = 6'h08, F_ADD = 6'h20;

    typedef int q_t[$];

    logic clk, rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, mem_timeout;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0] alu_control, state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal;
`endif

    int checks = 0;
    int failures = 0;
    logic [5:0] cur_op, cur_fn;
    int cur_z;

    mc_ctrl_fsm #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .mem_timeout(mem_timeout),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {known, alu code} for an R-type funct
    function automatic logic [4:0] r_info(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 5'h10;
            6'h22, 6'h23: return 5'h11;
            6'h24: return 5'h12;
            6'h25: return 5'h13;
            6'h26: return 5'h14;
            6'h00: return 5'h15;
            6'h02: return 5'h16;
            6'h03: return 5'h17;
            6'h2a: return 5'h18;
            6'h2b: return 5'h19;
            6'h27: return 5'h1a;
            6'h04: return 5'h1b;
            6'h06: return 5'h1c;
            6'h07: return 5'h1d;
            default: return 5'h00;
        endcase
    endfunction

    // {is immediate ALU op, alu code}
    function automatic logic [4:0] i_info(input logic [5:0] op);
        case (op)
            6'h08, 6'h09: return 5'h10;
            6'h0c: return 5'h12;
            6'h0d: return 5'h13;
            6'h0e: return 5'h14;
            6'h0a: return 5'h18;
            6'h0b: return 5'h19;
            6'h0f: return 5'h1e;
            default: return 5'h00;
        endcase
    endfunction

    function automatic q_t plan_of(input logic [5:0] op, input logic [5:0] fn);
        q_t p;
        logic [4:0] ri;
        ri = r_info(fn);
        p = {0, 1};
        if (op == R) begin
            if (fn == F_JR) p.push_back(13);
            else if (ri[4]) begin p.push_back(6); p.push_back(7); end
            else begin
                p.push_back(6);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                p.push_back(14);
`endif
            end
        end else if (op == LW) begin p.push_back(2); p.push_back(3); p.push_back(4); end
        else if (op == SW) begin p.push_back(2); p.push_back(5); end
        else if (op == BEQ || op == BNE) p.push_back(10);
        else if (op == J) p.push_back(11);
        else if (op == JAL) p.push_back(12);
        else if (i_info(op) != 5'h00) begin p.push_back(8); p.push_back(9); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        else p.push_back(14);
`endif
        return p;
    endfunction

    // {pc_write,pc_src,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,alu_src_a,alu_src_b,alu_control}
    function automatic logic [18:0] exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                             input logic z, input logic rdy);
        logic pw, io, mr, mw, iw, rw, sa;
        logic [1:0] ps, rd, mtr, sb;
        logic [3:0] alu;
        logic [4:0] ri, ii;
        ri = r_info(fn);
        ii = i_info(op);
        {pw, ps, io, mr, mw, iw, rw, rd, mtr, sa, sb, alu} = '0;
        case (st)
            0: begin mr = 1; sb = 2'b01; iw = rdy; pw = rdy; end
            1: sb = 2'b11;
            2: begin sa = 1; sb = 2'b10; end
            3: begin mr = 1; io = 1; end
            4: begin rw = 1; mtr = 2'b01; end
            5: begin mw = 1; io = 1; end
            6: begin sa = 1; alu = ri[3:0]; end
            7: begin rw = 1; rd = 2'b01; alu = ri[3:0]; end
            8: begin sa = 1; sb = 2'b10; alu = ii[3:0]; end
            9: begin rw = 1; alu = ii[3:0]; end
            10: begin sa = 1; alu = 4'd1; ps = 2'b01; pw = (op == BNE) ? !z : z; end
            11: begin ps = 2'b10; pw = 1; end
            12: begin ps = 2'b10; pw = 1; rw = 1; rd = 2'b10; mtr = 2'b10; end
            13: begin ps = 2'b11; pw = 1; end
            default: ;
        endcase
        return {pw, ps, io, mr, mw, iw, rw, rd, mtr, sa, sb, alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle in state st; k is the stall index within an access (-1 when not stalling)
    task automatic step(input int st, input logic rdy, input int k);
        logic [18:0] obs;
        logic to_exp;
        @(negedge clk);
        opcode = cur_op;
        funct = cur_fn;
        mem_ready = rdy;
        zero = (cur_z == 2) ? 1'($urandom_range(0, 1)) : 1'(cur_z);
        #1;
        obs = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control};
        to_exp = (k >= 0) && !rdy && (((k + 1) % MW) == 0);
        check($sformatf("state(op=%0h,fn=%0h)", cur_op, cur_fn), 32'(state), 32'(st));
        check($sformatf("ctrl_s%0d(op=%0h,fn=%0h)", st, cur_op, cur_fn), 32'(obs),
              32'(exp_ctrl(st, cur_op, cur_fn, zero, rdy)));
        check($sformatf("timeout_s%0d_k%0d", st, k), 32'(mem_timeout), 32'(to_exp));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        check("illegal", 32'(illegal), 32'(st == 14));
`endif
    endtask

    // fs/ms: stall cycles for fetch/memory access, negative means random
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int z,
                            input int fs, input int ms);
        q_t plan;
        int n;
        cur_op = op;
        cur_fn = fn;
        cur_z = z;
        plan = plan_of(op, fn);
        foreach (plan[i]) begin
            if (plan[i] == 0 || plan[i] == 3 || plan[i] == 5) begin
                n = (plan[i] == 0) ? fs : ms;
                if (n < 0) n = $urandom_range(0, 7);
                for (int k = 0; k < n; k++) step(plan[i], 1'b0, k);
                step(plan[i], 1'b1, -1);
            end else begin
                step(plan[i], 1'($urandom_range(0, 1)), -1);
            end
        end
    endtask

    initial begin
        logic [5:0] ops[19];
        logic [5:0] fns[15];
        logic [5:0] op, fn;
        ops = '{R, R, R, LW, SW, BEQ, BNE, J, JAL, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
                6'h0d, 6'h0e, 6'h0f, 6'h10, 6'h3f};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                6'h00, 6'h02, 6'h03, 6'h04, F_JR};
        rst_n = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        cur_op = '0; cur_fn = '0; cur_z = 0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        check("reset_writes", 32'({reg_write, mem_write, pc_write, ir_write}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Abandon a load mid-MEMRD, right on a timeout cycle
        cur_op = LW; cur_fn = '0; cur_z = 0;
        step(0, 1'b1, -1); step(1, 1'b1, -1); step(2, 1'b1, -1);
        step(3, 1'b0, 0); step(3, 1'b0, 1); step(3, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("midrd_reset_state", 32'(state), 32'd0);
        check("midrd_reset_writes", 32'({reg_write, mem_write}), 32'd0);
        check("midrd_reset_timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        do_instr(R, F_ADD, 0, 0, 0);
        do_instr(LW, '0, 0, 0, 2);
        do_instr(BEQ, '0, 1, 0, 0);
        do_instr(BNE, '0, 1, 0, 0);
        do_instr(BNE, '0, 0, 0, 0);
        do_instr(BEQ, '0, 0, 0, 0);
        do_instr(JAL, '0, 0, 0, 0);
        do_instr(R, F_JR, 0, 0, 0);
        do_instr(SW, '0, 0, 1, 4);
        do_instr(J, '0, 0, 10, 0);
        do_instr(6'h0f, '0, 0, 0, 0);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        do_instr(R, 6'h3f, 0, 0, 0);
        do_instr(6'h3f, '0, 0, 0, 0);
`endif

        for (int i = 0; i < 150; i++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            op = ops[$urandom_range(0, 16)];
            fn = fns[$urandom_range(0, 14)];
`else
            op = ops[$urandom_range(0, 18)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 14)];
`endif
            do_instr(op, fn, 2, -1, -1);
        end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        do_instr(6'h3f, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(14, 1'($urandom_range(0, 1)), -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
